// File: rtl/calc_pkg.sv
// Shared operator codes and FSM encodings for the keypad entry path.
package calc_pkg;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_NEG  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_DONE = 2'd2
   } entry_state_t;

   typedef enum logic [1:0] {
      H_ARMED = 2'd0,
      H_ACK   = 2'd1,
      H_REARM = 2'd2
   } hs_state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal digit append: mag*10+d, accepted only if it fits the signed magnitude limit
// and the operand still has room for another digit.
module digit_accum #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5,
   parameter int DW         = $clog2(MAX_DIGITS + 1)
) (
   input  logic [WIDTH-1:0] mag_i,
   input  logic [DW-1:0]    digits_i,
   input  logic [3:0]       d_i,
   output logic [WIDTH-1:0] next_mag_o,
   output logic             accept_o
);

   localparam int EW = WIDTH + 4;

   logic [EW-1:0] ext;
   logic [EW-1:0] limit;

   // Four guard bits hold limit*10+9 without wrapping, so the compare is exact.
   assign limit      = {5'b0, {(WIDTH-1){1'b1}}};
   assign ext        = {4'b0, mag_i} * EW'(10) + EW'(d_i);
   assign accept_o   = (digits_i < DW'(MAX_DIGITS)) && (d_i <= 4'd9) && (ext <= limit);
   assign next_mag_o = ext[WIDTH-1:0];

endmodule

// File: rtl/key_entry_accumulator.sv
// Keypad responder: acknowledges scanner events and assembles two signed operands plus
// an operator, pulsing calc_start when '=' completes a valid expression.
module key_entry_accumulator
   import calc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             read_input,
   input  logic [3:0]       keypad_input,
   input  logic [2:0]       operator_input,
   input  logic             equal_input,
   input  logic             soft_clr,
   output logic             key_read,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic [2:0]       op_code,
   output logic             calc_start,
   output logic [WIDTH-1:0] display_value,
   output logic             entry_ovf,
   output logic [1:0]       entry_state
);

   localparam int DW = $clog2(MAX_DIGITS + 1);

   hs_state_t    hs_q, hs_d;
   entry_state_t st_q, st_d;
   logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
   logic [DW-1:0]    dig_a_q, dig_a_d, dig_b_q, dig_b_d;
   logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [2:0]       op_q, op_d;
   logic             ovf_q, ovf_d;
   logic             cs_q, cs_d;

   logic evt, take, is_eq, is_op, is_dig;
   logic [WIDTH-1:0] acc_mag, acc_next;
   logic [DW-1:0]    acc_dig;
   logic             acc_ok;

   assign evt    = read_input | (operator_input != OP_NONE) | equal_input;
   assign take   = (hs_q == H_ARMED) && evt && !soft_clr;
   assign is_eq  = equal_input;
   assign is_op  = !equal_input && (operator_input != OP_NONE);
   assign is_dig = !equal_input && (operator_input == OP_NONE) && read_input;

   // S_DONE restarts A from empty, so the accumulator sees a zero operand there.
   always_comb begin
      acc_mag = mag_a_q;
      acc_dig = dig_a_q;
      if (st_q == S_B) begin
         acc_mag = mag_b_q;
         acc_dig = dig_b_q;
      end else if (st_q == S_DONE) begin
         acc_mag = '0;
         acc_dig = '0;
      end
   end

   digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .DW(DW)) u_acc (
      .mag_i      (acc_mag),
      .digits_i   (acc_dig),
      .d_i        (keypad_input),
      .next_mag_o (acc_next),
      .accept_o   (acc_ok)
   );

   always_comb begin
      hs_d = hs_q;
      case (hs_q)
         H_ARMED: if (take) hs_d = H_ACK;
         H_ACK:   hs_d = H_REARM;
         H_REARM: if (!evt) hs_d = H_ARMED;
         default: hs_d = H_ARMED;
      endcase
      // A clear mid-ack lets the ack pulse finish; elsewhere it re-arms.
      if (soft_clr && hs_q != H_ACK) hs_d = H_ARMED;
   end

   always_comb begin
      st_d     = st_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      dig_a_d  = dig_a_q;
      dig_b_d  = dig_b_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      op_d     = op_q;
      ovf_d    = ovf_q;
      cs_d     = 1'b0;
      if (soft_clr) begin
         st_d     = S_A;
         mag_a_d  = '0;
         mag_b_d  = '0;
         dig_a_d  = '0;
         dig_b_d  = '0;
         sign_a_d = 1'b0;
         sign_b_d = 1'b0;
         op_d     = OP_NONE;
         ovf_d    = 1'b0;
      end else if (take) begin
         case (st_q)
            S_A: begin
               if (is_dig) begin
                  if (acc_ok) begin
                     mag_a_d = acc_next;
                     dig_a_d = dig_a_q + 1'b1;
                  end else ovf_d = 1'b1;
               end else if (is_op) begin
                  if (operator_input == OP_NEG) begin
                     if (dig_a_q == '0) sign_a_d = ~sign_a_q;
                  end else if (is_arith(operator_input) && dig_a_q != '0) begin
                     op_d     = operator_input;
                     st_d     = S_B;
                     mag_b_d  = '0;
                     dig_b_d  = '0;
                     sign_b_d = 1'b0;
                     ovf_d    = 1'b0;
                  end
               end
            end
            S_B: begin
               if (is_dig) begin
                  if (acc_ok) begin
                     mag_b_d = acc_next;
                     dig_b_d = dig_b_q + 1'b1;
                  end else ovf_d = 1'b1;
               end else if (is_op) begin
                  if (operator_input == OP_NEG) begin
                     if (dig_b_q == '0) sign_b_d = ~sign_b_q;
                  end else if (is_arith(operator_input) && dig_b_q == '0) begin
                     op_d = operator_input;
                  end
               end else if (is_eq && dig_b_q != '0) begin
                  cs_d = 1'b1;
                  st_d = S_DONE;
               end
            end
            S_DONE: begin
               if (is_dig || (is_op && operator_input == OP_NEG)) begin
                  st_d     = S_A;
                  mag_a_d  = '0;
                  mag_b_d  = '0;
                  dig_a_d  = '0;
                  dig_b_d  = '0;
                  sign_a_d = is_op;
                  sign_b_d = 1'b0;
                  op_d     = OP_NONE;
                  ovf_d    = 1'b0;
                  if (is_dig) begin
                     if (acc_ok) begin
                        mag_a_d = acc_next;
                        dig_a_d = DW'(1);
                     end else ovf_d = 1'b1;
                  end
               end
            end
            default: st_d = S_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         hs_q     <= H_ARMED;
         st_q     <= S_A;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         dig_a_q  <= '0;
         dig_b_q  <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         op_q     <= OP_NONE;
         ovf_q    <= 1'b0;
         cs_q     <= 1'b0;
      end else begin
         hs_q     <= hs_d;
         st_q     <= st_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         dig_a_q  <= dig_a_d;
         dig_b_q  <= dig_b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         op_q     <= op_d;
         ovf_q    <= ovf_d;
         cs_q     <= cs_d;
      end
   end

   assign operand_a     = sign_a_q ? (~mag_a_q + 1'b1) : mag_a_q;
   assign operand_b     = sign_b_q ? (~mag_b_q + 1'b1) : mag_b_q;
   assign display_value = (st_q == S_B) ? operand_b : operand_a;
   assign key_read      = (hs_q == H_ACK);
   assign calc_start    = cs_q;
   assign op_code       = op_q;
   assign entry_ovf     = ovf_q;
   assign entry_state   = st_q;

endmodule
